// File: rtl/present_encrypt.sv
// PRESENT-80 iterative block encryption: 31 rounds, one per clock, then key whitening.
// Latency: ciphertext and ready registered 32 cycles after the last reset edge.
// No backpressure: rst both loads the operands and starts; a new rst aborts any run in flight.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset/start; msg/key are sampled while high
//   msg   - 64-bit plaintext
//   key   - 80-bit cipher key
//   ready - high while enc holds a finished ciphertext (level, held until next rst)
//   enc   - 64-bit ciphertext, zero until the first completion after rst
module present_encrypt (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] msg,
  input  logic [79:0] key,
  output logic        ready,
  output logic [63:0] enc
);

  // Round counter encoding: 1..31 = rounds, 32 = whitening, 33 = done (hold).
  localparam logic [5:0] RC_FIRST = 6'd1;
  localparam logic [5:0] RC_LAST  = 6'd31;
  localparam logic [5:0] RC_FINAL = 6'd32;
  localparam logic [5:0] RC_DONE  = 6'd33;

  logic [63:0] state_q, state_d;
  logic [79:0] kreg_q,  kreg_d;
  logic [5:0]  rc_q,    rc_d;
  logic        ready_q, ready_d;
  logic [63:0] enc_q,   enc_d;

  logic [63:0] add_key;
  logic [63:0] s_layer;
  logic [63:0] p_layer;
  logic [79:0] k_rot;
  logic [79:0] k_next;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Round datapath: add round key, substitute, permute.
  always_comb begin
    add_key = state_q ^ kreg_q[79:16];
    s_layer = '0;
    for (int n = 0; n < 16; n++) begin
      s_layer[4*n +: 4] = sbox(add_key[4*n +: 4]);
    end
    // Bit i lands at 16*i mod 63; bit 63 is a fixed point of the permutation.
    p_layer = '0;
    for (int i = 0; i < 63; i++) begin
      p_layer[(i * 16) % 63] = s_layer[i];
    end
    p_layer[63] = s_layer[63];
  end

  // Key schedule: rotate left 61, substitute top nibble, fold in round counter.
  always_comb begin
    k_rot           = {kreg_q[18:0], kreg_q[79:19]};
    k_next          = k_rot;
    k_next[79:76]   = sbox(k_rot[79:76]);
    k_next[19:15]   = k_rot[19:15] ^ rc_q[4:0];
  end

  always_comb begin
    state_d = state_q;
    kreg_d  = kreg_q;
    rc_d    = rc_q;
    ready_d = ready_q;
    enc_d   = enc_q;
    if (rst) begin
      state_d = msg;
      kreg_d  = key;
      rc_d    = RC_FIRST;
      ready_d = 1'b0;
      enc_d   = '0;
    end else if (rc_q >= RC_FIRST && rc_q <= RC_LAST) begin
      state_d = p_layer;
      kreg_d  = k_next;
      rc_d    = rc_q + 6'd1;
    end else if (rc_q == RC_FINAL) begin
      // kreg now holds K32, the whitening key.
      enc_d   = state_q ^ kreg_q[79:16];
      ready_d = 1'b1;
      rc_d    = RC_DONE;
    end
    // Any other counter value (done, or unreachable codes) holds everything.
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    kreg_q  <= kreg_d;
    rc_q    <= rc_d;
    ready_q <= ready_d;
    enc_q   <= enc_d;
  end

  assign ready = ready_q;
  assign enc   = enc_q;

endmodule

// File: tb/tb_present_encrypt.sv
// Directed bench for present_encrypt using published PRESENT-80 vectors.
module tb_present_encrypt;

  logic        clk;
  logic        rst;
  logic [63:0] msg;
  logic [79:0] key;
  logic        ready;
  logic [63:0] enc;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [79:0] ONES80 = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] CT_00  = 64'h5579C1387B228445;
  localparam logic [63:0] CT_0F  = 64'hE72C46C0F5945049;
  localparam logic [63:0] CT_F0  = 64'hA112FFC72F68417B;
  localparam logic [63:0] CT_FF  = 64'h3333DCD3213210D2;

  present_encrypt dut (
    .clk   (clk),
    .rst   (rst),
    .msg   (msg),
    .key   (key),
    .ready (ready),
    .enc   (enc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One reset edge (E0) loading m/k; returns #1 after that edge with rst low.
  task automatic start(input logic [63:0] m, input logic [79:0] k);
    msg = m;
    key = k;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full run from E0: checks cleared outputs, ready low at E31, result at E32.
  task automatic run_vec(input string tag, input logic [63:0] m, input logic [79:0] k,
                         input logic [63:0] exp_ct);
    start(m, k);
    chk1({tag, "_ready_e0"}, ready, 1'b0);
    chk64({tag, "_enc_e0"}, enc, 64'h0);
    step(31);
    chk1({tag, "_ready_e31"}, ready, 1'b0);
    step(1);
    chk1({tag, "_ready_e32"}, ready, 1'b1);
    chk64({tag, "_enc_e32"}, enc, exp_ct);
    step(3);
    chk1({tag, "_ready_e35"}, ready, 1'b1);
    chk64({tag, "_enc_e35"}, enc, exp_ct);
  endtask

  initial begin
    rst = 1'b1;
    msg = '0;
    key = '0;
    step(2);

    run_vec("v00", 64'h0, 80'h0, CT_00);
    run_vec("v0f", 64'h0, ONES80, CT_0F);
    run_vec("vf0", ONES64, 80'h0, CT_F0);
    run_vec("vff", ONES64, ONES80, CT_FF);

    // Reset while ready is high drops ready on that edge; then abort at E10.
    start(64'h0, 80'h0);
    chk1("abort_ready_drop", ready, 1'b0);
    chk64("abort_enc_clear", enc, 64'h0);
    step(9);
    start(ONES64, ONES80);
    chk1("abort_ready_e10", ready, 1'b0);
    step(31);
    chk1("abort_ready_e31", ready, 1'b0);
    step(1);
    chk1("abort_ready_e32", ready, 1'b1);
    chk64("abort_enc_e32", enc, CT_FF);

    // Inputs toggling without reset must not disturb the held result.
    for (int c = 0; c < 12; c++) begin
      msg = {$urandom, $urandom};
      key = {$urandom, $urandom, 16'($urandom)};
      step(1);
      chk1("hold_ready", ready, 1'b1);
      chk64("hold_enc", enc, CT_FF);
    end

    // rst held several edges: only the last loaded operands matter.
    msg = ONES64;
    key = ONES80;
    rst = 1'b1;
    step(1);
    msg = 64'h0123_4567_89AB_CDEF;
    step(1);
    chk1("multi_rst_ready", ready, 1'b0);
    start(64'h0, ONES80);
    step(31);
    chk1("multi_rst_ready_e31", ready, 1'b0);
    step(1);
    chk1("multi_rst_ready_e32", ready, 1'b1);
    chk64("multi_rst_enc_e32", enc, CT_0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
